// File: rtl/fpmul_vector_checker_if.sv
// Vector-load, run-control and DUT data bundle for fpmul_vector_checker.
// The master side is the bench; the checker is the slave.
interface fpmul_vector_checker_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 6
);
   logic             VEC_WE;
   logic [AW-1:0]    VEC_WADDR;
   logic [WIDTH-1:0] VEC_WA;
   logic [WIDTH-1:0] VEC_WB;
   logic [WIDTH-1:0] VEC_WZ;
   logic [AW:0]      N_VEC;
   logic             START;
   logic             HOLD;
   logic [WIDTH-1:0] DATA_Z;
   logic [WIDTH-1:0] DATA_A;
   logic [WIDTH-1:0] DATA_B;
   logic             BUSY;
   logic             DONE;
   logic             PASS;
   logic [15:0]      ERR_COUNT;
   logic [AW-1:0]    FIRST_ERR;

   modport master (
      output VEC_WE, VEC_WADDR, VEC_WA, VEC_WB, VEC_WZ,
      output N_VEC, START, HOLD, DATA_Z,
      input  DATA_A, DATA_B, BUSY, DONE, PASS,
      input  ERR_COUNT, FIRST_ERR
   );

   modport slave (
      input  VEC_WE, VEC_WADDR, VEC_WA, VEC_WB, VEC_WZ,
      input  N_VEC, START, HOLD, DATA_Z,
      output DATA_A, DATA_B, BUSY, DONE, PASS,
      output ERR_COUNT, FIRST_ERR
   );
endinterface

// File: rtl/fpmul_vector_checker.sv
// Plays stored A/B vectors into a free-running FP multiplier and checks
// each result against the stored product after a fixed latency.
module fpmul_vector_checker #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 64,
   parameter int AW        = 6,
   parameter int LATENCY   = 4,
   parameter int MASK_LSBS = 0
) (
   input logic                 CLK,
   input logic                 RST_n,
   fpmul_vector_checker_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_DONE
   } state_t;

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] CMP_MASK =
      ~((ONE << MASK_LSBS) - ONE);
   localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

   state_t state, state_nx;

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [WIDTH-1:0] mem_z [DEPTH];

   logic [AW-1:0]    idx;
   logic [AW:0]      n_run;
   logic [AW:0]      n_clamp;
   logic [CW-1:0]    drain_cnt;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [15:0]      err_cnt;
   logic [AW-1:0]    first_err;

   logic             dl_v [LATENCY];
   logic [WIDTH-1:0] dl_z [LATENCY];
   logic [AW-1:0]    dl_i [LATENCY];

   logic idle_or_done;
   logic start_ok;
   logic issue;
   logic last_issue;
   logic mismatch;

   assign idle_or_done = (state == S_IDLE) ||
                         (state == S_DONE);
   assign start_ok = idle_or_done && bus.START;
   assign n_clamp  = (bus.N_VEC > DEPTH_N) ?
                     DEPTH_N : bus.N_VEC;
   assign issue    = (state == S_ISSUE) && !bus.HOLD;
   assign last_issue = issue &&
      ({1'b0, idx} == (n_run - 1'b1));
   assign mismatch = dl_v[LATENCY-1] &&
      (((bus.DATA_Z ^ dl_z[LATENCY-1]) & CMP_MASK) != '0);

   always_ff @(posedge CLK) begin
      if (!RST_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE:
            if (bus.START)
               state_nx = (n_clamp == '0) ? S_DONE : S_ISSUE;
         S_ISSUE:
            if (last_issue) state_nx = S_DRAIN;
         S_DRAIN:
            if (drain_cnt == '0) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Vector memory is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (bus.VEC_WE && idle_or_done) begin
         mem_a[bus.VEC_WADDR] <= bus.VEC_WA;
         mem_b[bus.VEC_WADDR] <= bus.VEC_WB;
         mem_z[bus.VEC_WADDR] <= bus.VEC_WZ;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         idx       <= '0;
         n_run     <= '0;
         drain_cnt <= '0;
         data_a    <= '0;
         data_b    <= '0;
         err_cnt   <= '0;
         first_err <= '0;
      end else begin
         if (start_ok) begin
            idx       <= '0;
            n_run     <= n_clamp;
            err_cnt   <= '0;
            first_err <= '0;
         end else if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err <= dl_i[LATENCY-1];
         end
         if (issue) begin
            data_a <= mem_a[idx];
            data_b <= mem_b[idx];
            idx    <= idx + 1'b1;
         end
         if (last_issue)
            drain_cnt <= CW'(LATENCY - 1);
         else if (state == S_DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
      end
   end

   // Bubbles and non-issue cycles enter as invalid stages.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         for (int i = 0; i < LATENCY; i++) dl_v[i] <= 1'b0;
      end else begin
         dl_v[0] <= issue;
         for (int i = 1; i < LATENCY; i++) dl_v[i] <= dl_v[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      dl_z[0] <= mem_z[idx];
      dl_i[0] <= idx;
      for (int i = 1; i < LATENCY; i++) begin
         dl_z[i] <= dl_z[i-1];
         dl_i[i] <= dl_i[i-1];
      end
   end

   assign bus.DATA_A    = data_a;
   assign bus.DATA_B    = data_b;
   assign bus.BUSY      = (state == S_ISSUE) ||
                          (state == S_DRAIN);
   assign bus.DONE      = (state == S_DONE);
   assign bus.PASS      = (state == S_DONE) && (err_cnt == '0);
   assign bus.ERR_COUNT = err_cnt;
   assign bus.FIRST_ERR = first_err;
endmodule

// File: tb/tb_fpmul_vector_checker.sv
// Bench: two checkers (exact and 1-LSB tolerant) beside an ideal
// latency-4 multiplier model with an optional single-result corruption.
module tb_fpmul_vector_checker;
  localparam int W = 32;
  localparam int D = 16;
  localparam int A = 4;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         we = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [W-1:0] wa = '0, wb = '0, wz = '0;
  logic [A:0]   n_vec = '0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] z;

  fpmul_vector_checker_if #(.WIDTH(W), .AW(A)) bus0 ();
  fpmul_vector_checker_if #(.WIDTH(W), .AW(A)) bus1 ();

  assign bus0.VEC_WE = we;    assign bus1.VEC_WE = we;
  assign bus0.VEC_WADDR = waddr; assign bus1.VEC_WADDR = waddr;
  assign bus0.VEC_WA = wa;    assign bus1.VEC_WA = wa;
  assign bus0.VEC_WB = wb;    assign bus1.VEC_WB = wb;
  assign bus0.VEC_WZ = wz;    assign bus1.VEC_WZ = wz;
  assign bus0.N_VEC = n_vec;  assign bus1.N_VEC = n_vec;
  assign bus0.START = start;  assign bus1.START = start;
  assign bus0.HOLD = hold;    assign bus1.HOLD = hold;
  assign bus0.DATA_Z = z;     assign bus1.DATA_Z = z;

  fpmul_vector_checker #(
    .WIDTH(W), .DEPTH(D), .AW(A), .LATENCY(L), .MASK_LSBS(0)
  ) u0 (.CLK(clk), .RST_n(rst_n), .bus(bus0));

  fpmul_vector_checker #(
    .WIDTH(W), .DEPTH(D), .AW(A), .LATENCY(L), .MASK_LSBS(1)
  ) u1 (.CLK(clk), .RST_n(rst_n), .bus(bus1));

  bit           corrupt_on = 1'b0;
  logic [W-1:0] corrupt_a = 32'hBFC00000;

  function automatic logic [W-1:0] model_fn(
    input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: r = 32'h3F800000;
      {32'h40000000, 32'h40400000}: r = 32'h40C00000;
      {32'hBFC00000, 32'h40000000}: r = 32'hC0400000;
      {32'h00000000, 32'h40A00000}: r = 32'h00000000;
      default: r = a * b;
    endcase
    if (corrupt_on && a == corrupt_a) r = r ^ 32'h1;
    return r;
  endfunction

  // L-1 registers: the result of operands set at edge k is seen at k+L.
  logic [W-1:0] pipe [L-1];
  always @(posedge clk) begin
    pipe[0] <= model_fn(bus0.DATA_A, bus0.DATA_B);
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign z = pipe[L-2];

  logic [W-1:0] va [D];
  logic [W-1:0] vb [D];
  logic [W-1:0] vz [D];

  int n_applied = 0;
  int n_miscmp = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic write_vec(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic [W-1:0] zz);
    @(negedge clk);
    we = 1'b1; waddr = A'(i); wa = a; wb = b; wz = zz;
    va[i] = a; vb[i] = b; vz[i] = zz;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic ref_run(input int nv, input logic [63:0] hp,
                         output int cyc, output int e0,
                         output int f0, output int e1,
                         output int f1);
    int n, iss, last;
    logic [W-1:0] d;
    n = (nv > D) ? D : nv;
    iss = 0; last = 0;
    for (int j = 1; iss < n; j++) begin
      if (!(j < 64 && hp[j])) begin
        iss++; last = j;
      end
    end
    cyc = (n == 0) ? 0 : last + L;
    e0 = 0; f0 = 0; e1 = 0; f1 = 0;
    for (int i = 0; i < n; i++) begin
      d = model_fn(va[i], vb[i]) ^ vz[i];
      if (d != '0) begin
        if (e0 == 0) f0 = i;
        e0++;
      end
      if ((d & ~32'h1) != '0) begin
        if (e1 == 0) f1 = i;
        e1++;
      end
    end
  endtask

  task automatic run(input string nm, input int nv,
                     input logic [63:0] hp, input bit disturb,
                     input int ecyc, input int e0, input int f0,
                     input int e1, input int f1);
    int cyc, n, iss;
    n = (nv > D) ? D : nv;
    @(negedge clk);
    n_vec = (A+1)'(nv); start = 1'b1; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; iss = 0;
    while (!bus0.DONE && cyc < 200) begin
      hold = (cyc + 1 < 64) ? hp[cyc+1] : 1'b0;
      if (disturb && cyc == 2) begin
        start = 1'b1; we = 1'b1; waddr = A'(3);
        wa = '1; wb = '1; wz = '1;
      end
      @(negedge clk);
      start = 1'b0; we = 1'b0;
      cyc++;
      if (!hold && iss < n) iss++;
      if (iss > 0) begin
        chk({nm, " data_a"}, bus0.DATA_A, va[iss-1]);
        chk({nm, " data_b"}, bus0.DATA_B, vb[iss-1]);
      end
    end
    hold = 1'b0;
    chk({nm, " done_cycle"}, cyc, ecyc);
    chk({nm, " busy"}, bus0.BUSY, 0);
    chk({nm, " err0"}, bus0.ERR_COUNT, e0);
    chk({nm, " first0"}, bus0.FIRST_ERR, f0);
    chk({nm, " pass0"}, bus0.PASS, e0 == 0);
    chk({nm, " err1"}, bus1.ERR_COUNT, e1);
    chk({nm, " first1"}, bus1.FIRST_ERR, f1);
    chk({nm, " pass1"}, bus1.PASS, e1 == 0);
  endtask

  typedef struct {
    string       nm;
    int          nv;
    logic [63:0] hp;
    bit          corrupt;
    bit          disturb;
    int          cyc;
    int          e0;
    int          f0;
    int          e1;
    int          f1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int ecyc, e0, f0, e1, f1, nv;
    logic [W-1:0] ra, rb, rz;
    logic [63:0] hp;

    tbl[0] = '{"t1", 4, 64'h0, 0, 0, 8, 0, 0, 0, 0};
    tbl[1] = '{"t2", 4, 64'h0, 1, 0, 8, 1, 2, 0, 0};
    tbl[2] = '{"t3", 4, 64'h38, 0, 0, 11, 0, 0, 0, 0};
    tbl[3] = '{"t4_zero", 0, 64'h0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{"t4_clamp", D + 5, 64'h0, 0, 0, D + L, 0, 0, 0, 0};
    tbl[5] = '{"t6", 4, 64'h0, 0, 1, 8, 0, 0, 0, 0};
    tbl[6] = '{"t2_hold", 4, 64'h14, 1, 0, 10, 1, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst data_a", bus0.DATA_A, 0);
    chk("rst data_b", bus0.DATA_B, 0);
    chk("rst busy", bus0.BUSY, 0);
    chk("rst done", bus0.DONE, 0);
    chk("rst pass", bus0.PASS, 0);
    chk("rst err", bus0.ERR_COUNT, 0);
    chk("rst first", bus0.FIRST_ERR, 0);
    chk("rst done1", bus1.DONE, 0);
    rst_n = 1'b1;

    write_vec(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    write_vec(1, 32'h40000000, 32'h40400000, 32'h40C00000);
    write_vec(2, 32'hBFC00000, 32'h40000000, 32'hC0400000);
    write_vec(3, 32'h00000000, 32'h40A00000, 32'h00000000);
    for (int i = 4; i < D; i++) begin
      ra = $urandom; rb = $urandom;
      write_vec(i, ra, rb, ra * rb);
    end

    for (int t = 0; t < 7; t++) begin
      corrupt_on = tbl[t].corrupt;
      run(tbl[t].nm, tbl[t].nv, tbl[t].hp, tbl[t].disturb,
          tbl[t].cyc, tbl[t].e0, tbl[t].f0, tbl[t].e1, tbl[t].f1);
    end
    corrupt_on = 1'b1;

    // Reset while vector 2 is about to issue.
    @(negedge clk);
    n_vec = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5 busy_before", bus0.BUSY, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5 busy", bus0.BUSY, 0);
    chk("t5 done", bus0.DONE, 0);
    chk("t5 pass", bus0.PASS, 0);
    chk("t5 err", bus0.ERR_COUNT, 0);
    chk("t5 first", bus0.FIRST_ERR, 0);
    chk("t5 data_a", bus0.DATA_A, 0);
    corrupt_on = 1'b0;
    run("t5_rerun", 4, 64'h0, 0, 8, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < D; i++) begin
        ra = $urandom; rb = $urandom;
        rz = model_fn(ra, rb);
        case ($urandom_range(0, 3))
          0: rz = rz ^ 32'h1;
          1: rz = rz ^ (32'h1 << $urandom_range(1, 31));
          default: ;
        endcase
        write_vec(i, ra, rb, rz);
      end
      nv = $urandom_range(0, D + 3);
      hp = {$urandom, $urandom} & {$urandom, $urandom};
      ref_run(nv, hp, ecyc, e0, f0, e1, f1);
      run($sformatf("rand%0d", r), nv, hp, 0,
          ecyc, e0, f0, e1, f1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_applied, n_miscmp);
    $finish;
  end
endmodule
